// File: rtl/dma_cmd_responder_pkg.sv
// dma_cmd_responder_pkg
//   Shared widths, the latched command record and the responder state enum
//   for the DMA command responder and its arbiter.
package dma_cmd_responder_pkg;

    localparam int ID_WIDTH       = 4;
    localparam int ADDR_WIDTH     = 32;
    localparam int DMA_SIZE_WIDTH = 16;

    // Field order matches the command bus: source, destination, size.
    typedef struct packed {
        logic [ID_WIDTH-1:0]       src_ID;
        logic [ADDR_WIDTH-1:0]     src_addr;
        logic [ID_WIDTH-1:0]       dst_ID;
        logic [ADDR_WIDTH-1:0]     dst_addr;
        logic [DMA_SIZE_WIDTH-1:0] size;
    } dma_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ISSUE,
        ST_BUSY,
        ST_DONE
    } dma_resp_state_t;

endpackage

// File: rtl/dma_cmd_responder_rr.sv
// dma_rr_arbiter
//   Combinational round-robin pick. The search starts at last_i+1 and wraps
//   modulo N_MASTERS (N need not be a power of two).
//   Ports:
//     req_i      in   N_MASTERS  request levels
//     last_i     in   IDX_W      index of the most recently served master
//     gnt_o      out  N_MASTERS  one-hot winner (0 when no request)
//     gnt_idx_o  out  IDX_W      index of the winner
//     any_o      out  1          at least one request present
module dma_rr_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]     last_i,
    output logic [N_MASTERS-1:0] gnt_o,
    output logic [IDX_W-1:0]     gnt_idx_o,
    output logic                 any_o
);

    // One extra bit holds last_i + offset before the wrap (max 2N-1).
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = |req_i;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int off = 1; off <= N_MASTERS; off++) begin
            sum = {1'b0, last_i} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(N_MASTERS)) begin
                sum = sum - (IDX_W+1)'(N_MASTERS);
            end
            idx = sum[IDX_W-1:0];
            if (!found && req_i[idx]) begin
                found     = 1'b1;
                gnt_idx_o = idx;
            end
        end
        if (found) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/dma_cmd_responder.sv
// dma_cmd_responder
//   Responder end of the DMA command handshake. Grants one master at a time
//   (round-robin), captures its command on start, forwards it to the DMA
//   engine over valid/ready and pulses done[g] when the engine completes.
//   Optional feature: define DMA_RESP_TIMEOUT_EN to revoke a grant that sees
//   no start within TIMEOUT_CYCLES cycles; otherwise timeout is tied to 0.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     req / permit             per-master request level / registered one-hot grant
//     src_ID..size, start      shared command bus and its strobe
//     done                     one-hot, one-cycle completion pulse
//     eng_valid / eng_ready    command handshake to the engine
//     eng_src_ID..eng_size     latched command
//     eng_done                 engine completion pulse
//     busy                     state is not IDLE
//     timeout                  one-cycle pulse on grant revocation by timer
module dma_cmd_responder
    import dma_cmd_responder_pkg::*;
#(
    parameter int N_MASTERS      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_MASTERS-1:0]      req,
    output logic [N_MASTERS-1:0]      permit,
    input  logic [ID_WIDTH-1:0]       src_ID,
    input  logic [ADDR_WIDTH-1:0]     src_addr,
    input  logic [ID_WIDTH-1:0]       dst_ID,
    input  logic [ADDR_WIDTH-1:0]     dst_addr,
    input  logic [DMA_SIZE_WIDTH-1:0] size,
    input  logic                      start,
    output logic [N_MASTERS-1:0]      done,
    output logic                      eng_valid,
    input  logic                      eng_ready,
    output logic [ID_WIDTH-1:0]       eng_src_ID,
    output logic [ADDR_WIDTH-1:0]     eng_src_addr,
    output logic [ID_WIDTH-1:0]       eng_dst_ID,
    output logic [ADDR_WIDTH-1:0]     eng_dst_addr,
    output logic [DMA_SIZE_WIDTH-1:0] eng_size,
    input  logic                      eng_done,
    output logic                      busy,
    output logic                      timeout
);

    localparam int IDX_W = $clog2(N_MASTERS);

    dma_resp_state_t        state_q, state_d;
    logic [IDX_W-1:0]       g_q, g_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [N_MASTERS-1:0]   permit_q, permit_d;
    dma_cmd_t               cmd_q, cmd_d;

    logic [N_MASTERS-1:0]   arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_any;

`ifdef DMA_RESP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES+1);
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;
`else
    // Keeps the timer parameter referenced when the timer is compiled out.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    dma_rr_arbiter #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req_i     (req),
        .last_i    (last_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        last_d   = last_q;
        permit_d = permit_q;
        cmd_d    = cmd_q;
`ifdef DMA_RESP_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    permit_d = arb_gnt;
                    g_d      = arb_idx;
                    state_d  = ST_GRANT;
`ifdef DMA_RESP_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            ST_GRANT: begin
                // start wins over both a dropped request and timer expiry.
                if (start) begin
                    cmd_d    = '{src_ID: src_ID, src_addr: src_addr,
                                 dst_ID: dst_ID, dst_addr: dst_addr, size: size};
                    permit_d = '0;
                    state_d  = (size == '0) ? ST_DONE : ST_ISSUE;
                end else if (!req[g_q]) begin
                    permit_d = '0;
                    last_d   = g_q;
                    state_d  = ST_IDLE;
                end
`ifdef DMA_RESP_TIMEOUT_EN
                // cnt_q counts completed GRANT cycles; this is the last allowed one.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
                    permit_d  = '0;
                    last_d    = g_q;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_ISSUE: begin
                if (eng_ready) begin
                    state_d = eng_done ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (eng_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                last_d  = g_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            g_q      <= '0;
            last_q   <= IDX_W'(N_MASTERS-1);
            permit_q <= '0;
            cmd_q    <= '0;
`ifdef DMA_RESP_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            last_q   <= last_d;
            permit_q <= permit_d;
            cmd_q    <= cmd_d;
`ifdef DMA_RESP_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // DONE lasts exactly one cycle, so decoding it gives the one-cycle pulse.
    always_comb begin
        done = '0;
        if (state_q == ST_DONE) begin
            done[g_q] = 1'b1;
        end
    end

    assign permit       = permit_q;
    assign eng_valid    = (state_q == ST_ISSUE);
    assign busy         = (state_q != ST_IDLE);
    assign eng_src_ID   = cmd_q.src_ID;
    assign eng_src_addr = cmd_q.src_addr;
    assign eng_dst_ID   = cmd_q.dst_ID;
    assign eng_dst_addr = cmd_q.dst_addr;
    assign eng_size     = cmd_q.size;

`ifdef DMA_RESP_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dma_cmd_responder.sv
module tb_dma_cmd_responder;
    import dma_cmd_responder_pkg::*;

    localparam int N = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N-1:0]              req, permit, done;
    logic [ID_WIDTH-1:0]       src_ID, dst_ID, eng_src_ID, eng_dst_ID;
    logic [ADDR_WIDTH-1:0]     src_addr, dst_addr, eng_src_addr, eng_dst_addr;
    logic [DMA_SIZE_WIDTH-1:0] size, eng_size;
    logic                      start, eng_valid, eng_ready, eng_done, busy, timeout;

    dma_cmd_t bus, eng_cmd;
    assign src_ID   = bus.src_ID;
    assign src_addr = bus.src_addr;
    assign dst_ID   = bus.dst_ID;
    assign dst_addr = bus.dst_addr;
    assign size     = bus.size;
    assign eng_cmd  = {eng_src_ID, eng_src_addr, eng_dst_ID, eng_dst_addr, eng_size};

    dma_cmd_responder #(.N_MASTERS(N), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .req(req), .permit(permit),
        .src_ID(src_ID), .src_addr(src_addr), .dst_ID(dst_ID), .dst_addr(dst_addr),
        .size(size), .start(start), .done(done),
        .eng_valid(eng_valid), .eng_ready(eng_ready),
        .eng_src_ID(eng_src_ID), .eng_src_addr(eng_src_addr),
        .eng_dst_ID(eng_dst_ID), .eng_dst_addr(eng_dst_addr), .eng_size(eng_size),
        .eng_done(eng_done), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int model_last;   // reference round-robin pointer

    typedef struct {
        logic [N-1:0] m;
        int           g;
        dma_cmd_t     c;
        int           rdy;
        int           dd;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] r;
        r = N'(1) << i;
        return r;
    endfunction

    // Closest requester strictly above the last served one, wrapping mod N.
    function automatic int rr_pick(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (((m >> c) & N'(1)) != '0) return c;
        end
        return -1;
    endfunction

    function automatic dma_cmd_t mkc(input int sid, input int sa, input int did,
                                     input int da, input int sz);
        dma_cmd_t c;
        c.src_ID   = ID_WIDTH'(sid);
        c.src_addr = ADDR_WIDTH'(sa);
        c.dst_ID   = ID_WIDTH'(did);
        c.dst_addr = ADDR_WIDTH'(da);
        c.size     = DMA_SIZE_WIDTH'(sz);
        return c;
    endfunction

    function automatic vec_t mkv(input logic [N-1:0] m, input int g, input dma_cmd_t c,
                                 input int rdy, input int dd);
        vec_t v;
        v.m = m; v.g = g; v.c = c; v.rdy = rdy; v.dd = dd;
        return v;
    endfunction

    // One full transaction starting from IDLE. rdy = cycles of eng_ready low
    // while valid; dd = cycles from handshake to eng_done (0 = same cycle).
    task automatic do_txn(input logic [N-1:0] m, input int exp_g, input dma_cmd_t c,
                          input int rdy, input int dd);
        req = m;
        tick;
        chk("grant", permit, oh(exp_g));
        bus   = c;
        start = 1'b1;
        tick;
        start = 1'b0;
        bus   = ~c;   // junk on the bus must not disturb the latched command
        chk("permit_clear", permit, '0);
        if (c.size == '0) begin
            chk("zero_done", {eng_valid, done}, {1'b0, oh(exp_g)});
        end else begin
            chk("eng_issue", {eng_valid, done, eng_cmd}, {1'b1, N'(0), c});
            for (int i = 0; i < rdy; i++) begin
                tick;
                chk("bp_stable", {eng_valid, done, eng_cmd}, {1'b1, N'(0), c});
            end
            eng_ready = 1'b1;
            eng_done  = (dd == 0);
            tick;
            eng_ready = 1'b0;
            eng_done  = 1'b0;
            chk("valid_drop", eng_valid, 1'b0);
            if (dd != 0) begin
                chk("busy_wait", {busy, done}, {1'b1, N'(0)});
                for (int i = 1; i < dd; i++) begin
                    tick;
                    chk("wait_nodone", done, '0);
                end
                eng_done = 1'b1;
                tick;
                eng_done = 1'b0;
            end
            chk("done_pulse", done, oh(exp_g));
        end
        tick;
        chk("done_end", {timeout, busy, done}, '0);
        model_last = exp_g;
    endtask

    initial begin
        dma_cmd_t c;
        logic [N-1:0] m;
        int g;

        rst = 1'b1; req = '0; bus = '0; start = 1'b0; eng_ready = 1'b0; eng_done = 1'b0;
        repeat (3) tick;
        rst = 1'b0;
        chk("reset_state", {permit, done, eng_valid, busy, timeout, eng_cmd}, '0);
        model_last = N - 1;

        // Directed table from reset: contention order 0,2,3,0 then mixed cases.
        tbl[0] = mkv(4'b1101, 0, mkc(2, 'h100, 1, 'h200, 16), 2, 5);
        tbl[1] = mkv(4'b1101, 2, mkc(5, 'h1234, 6, 'h5678, 0), 0, 0);
        tbl[2] = mkv(4'b1101, 3, mkc(7, 'hdead0, 8, 'hbeef0, 32), 10, 3);
        tbl[3] = mkv(4'b1101, 0, mkc(1, 'h10, 2, 'h20, 4), 1, 0);
        tbl[4] = mkv(4'b0001, 0, mkc(3, 'h30, 4, 'h40, 1), 0, 1);
        tbl[5] = mkv(4'b0011, 1, mkc(9, 'h50, 10, 'h60, 0), 0, 0);
        tbl[6] = mkv(4'b0011, 0, mkc(11, 'h70, 12, 'h80, 7), 3, 2);
        tbl[7] = mkv(4'b1000, 3, mkc(13, 'h90, 14, 'ha0, 9), 0, 0);
        tbl[8] = mkv(4'b0110, 1, mkc(15, 'hb0, 0, 'hc0, 255), 5, 4);
        for (int i = 0; i < 9; i++) begin
            do_txn(tbl[i].m, tbl[i].g, tbl[i].c, tbl[i].rdy, tbl[i].dd);
        end

        // Request dropped during GRANT: grant revoked, pointer moves past 2.
        req = 4'b0100;
        tick;
        chk("drop_grant", permit, oh(2));
        req = '0;
        tick;
        chk("drop_revoke", {permit, busy, timeout}, '0);
        model_last = 2;
        do_txn(4'b1111, 3, mkc(1, 1, 2, 2, 3), 0, 1);

`ifdef DMA_RESP_TIMEOUT_EN
        // Grant master 1 and never start: revoked after 8 cycles, 2 then wins.
        req = 4'b0110;
        tick;
        chk("to_grant", permit, oh(1));
        for (int k = 1; k < 8; k++) begin
            tick;
            chk("to_hold", {permit, timeout}, {oh(1), 1'b0});
        end
        tick;
        chk("to_fire", {permit, timeout, busy}, {N'(0), 1'b1, 1'b0});
        tick;
        chk("to_regrant", {permit, timeout}, {oh(2), 1'b0});
        req = '0;
        tick;
        chk("to_drop", {permit, busy}, '0);
        model_last = 2;
`else
        // Without the timer the grant waits indefinitely.
        req = 4'b0110;
        tick;
        chk("hold_grant", permit, oh(1));
        for (int k = 0; k < 80; k++) begin
            tick;
            chk("hold_no_timeout", {permit, timeout, busy}, {oh(1), 1'b0, 1'b1});
        end
        req = '0;
        tick;
        chk("hold_drop", {permit, busy}, '0);
        model_last = 1;
`endif

        // Randomized transactions against the round-robin reference.
        for (int t = 0; t < 40; t++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            g = rr_pick(m, model_last);
            c = mkc($urandom_range(0, 15), $urandom, $urandom_range(0, 15), $urandom,
                    ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 65535));
            do_txn(m, g, c, $urandom_range(0, 4), $urandom_range(0, 4));
        end

        // Reset in BUSY aborts with no done pulse; priority returns to master 0.
        req = 4'b0001;
        tick;
        chk("rst_grant", permit, oh(rr_pick(4'b0001, model_last)));
        bus = mkc(3, 'h300, 4, 'h400, 8);
        start = 1'b1;
        tick;
        start = 1'b0;
        eng_ready = 1'b1;
        tick;
        eng_ready = 1'b0;
        chk("rst_in_busy", {busy, eng_valid}, 2'b10);
        rst = 1'b1;
        req = '0;
        tick;
        rst = 1'b0;
        chk("rst_clear", {permit, done, eng_valid, busy, timeout, eng_cmd}, '0);
        eng_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            eng_done = 1'b0;
            chk("rst_no_done", {done, busy}, '0);
        end
        model_last = N - 1;
        do_txn(4'b1111, 0, mkc(6, 'h600, 7, 'h700, 2), 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
